// File: rtl/sqrt_requester_if.sv
// Operand and result streams between upstream logic and the square-root requester.
interface sqrt_requester_if #(
  parameter int unsigned WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;

  // Requester side: consumes operands, produces results.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err
  );

  // Upstream side: produces operands, consumes results.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/sqrt_requester.sv
// Initiator for the start/ready square-root estimate core: takes one operand at a
// time, pulses start, waits for the core's ready (with timeout) and returns the
// result on a valid/ready stream. Tracks delivered results and timeouts.
module sqrt_requester #(
  parameter int unsigned WIDTH          = 64,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 16
) (
  input  logic               clock,
  input  logic               reset,
  sqrt_requester_if.slave    strm,
  output logic               core_start,
  output logic [WIDTH-1:0]   core_x,
  input  logic               core_ready,
  input  logic [WIDTH-1:0]   core_y,
  output logic               busy,
  output logic [CNT_W-1:0]   done_count,
  output logic [CNT_W-1:0]   err_count
);

  localparam int unsigned     TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TMO = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_CLR,
    ST_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic               core_start_q, core_start_d;
  logic [WIDTH-1:0]   core_x_q, core_x_d;
  logic [TW-1:0]      tcnt_q, tcnt_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_err_q, out_err_d;
  logic [CNT_W-1:0]   done_q, done_d;
  logic [CNT_W-1:0]   err_q, err_d;

  logic               in_ready;
  logic [TW-1:0]      tcnt_inc;
  logic               timeout;

  // Single outstanding operation: accept only when idle and the result slot is free.
  assign in_ready = reset && (state_q == ST_IDLE) && !out_valid_q;

  assign tcnt_inc = tcnt_q + TW'(1);
  assign timeout  = (tcnt_inc == TMO);

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    core_start_d = core_start_q;
    core_x_d     = core_x_q;
    tcnt_d       = tcnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_err_d    = out_err_q;
    done_d       = done_q;
    err_d        = err_q;

    if (out_valid_q && strm.out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (strm.in_valid && in_ready) begin
          core_x_d     = strm.in_data;
          core_start_d = 1'b1;
          state_d      = ST_START;
        end
      end
      ST_START: begin
        core_start_d = 1'b0;
        tcnt_d       = '0;
        state_d      = ST_CLR;
      end
      ST_CLR: begin
        // Ready may still be high from the previous operation; wait for it to drop.
        tcnt_d = tcnt_inc;
        if (timeout) begin
          out_data_d  = '0;
          out_err_d   = 1'b1;
          out_valid_d = 1'b1;
          if (err_q != '1) err_d = err_q + CNT_W'(1);
          state_d     = ST_IDLE;
        end else if (!core_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A capture on the timeout edge wins over the timeout.
        tcnt_d = tcnt_inc;
        if (core_ready) begin
          out_data_d  = core_y;
          out_err_d   = 1'b0;
          out_valid_d = 1'b1;
          done_d      = done_q + CNT_W'(1);
          state_d     = ST_IDLE;
        end else if (timeout) begin
          out_data_d  = '0;
          out_err_d   = 1'b1;
          out_valid_d = 1'b1;
          if (err_q != '1) err_d = err_q + CNT_W'(1);
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      core_start_q <= 1'b0;
      core_x_q     <= '0;
      tcnt_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_err_q    <= 1'b0;
      done_q       <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      core_start_q <= core_start_d;
      core_x_q     <= core_x_d;
      tcnt_q       <= tcnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_err_q    <= out_err_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign strm.in_ready  = in_ready;
  assign strm.out_valid = out_valid_q;
  assign strm.out_data  = out_data_q;
  assign strm.out_err   = out_err_q;
  assign core_start     = core_start_q;
  assign core_x         = core_x_q;
  assign busy           = (state_q != ST_IDLE);
  assign done_count     = done_q;
  assign err_count      = err_q;

endmodule
